snake_render_engine: RTL and testbench

SNAKE_RENDER_ENGINE -- requirements
Module: snake_render_engine

---
 rtl/snake_render_engine.sv | 236 +++++++++++++++++++++++
 tb/tb_snake_render_engine.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_render_engine.sv
// snake_render_engine: per-pixel figure/colour lookup for a block-based snake game.
// X/Y are split into block and in-block coordinates, and the head, body and fruit
// hits are resolved by priority. The result is registered, so every pixel output
// has one clock of latency.
// The body is held in an external memory. During the horizontal blanking before
// each block row, a three-state FSM (IDLE/SCAN/DRAIN) reads every segment and
// builds a one-row bitmap.
// Optional feature: define SNAKE_RENDER_GRID_EN to draw grid lines (colour 11)
// on background blocks at x_local == 0 or y_local == 0.
//
// Body memory read protocol: body_addr is issued in cycle n, and
// snake_body_x/snake_body_y carry that segment in cycle n+1. There is no
// stall, so one address is issued every cycle while the FSM is in SCAN.
module snake_render_engine #(
  parameter int GRID_W   = 80,
  parameter int GRID_H   = 60,
  parameter int MAX_LEN  = 64,
  parameter int N_FRUIT  = 2,
  parameter int H_ACTIVE = 640,
  localparam int LEN_W   = $clog2(MAX_LEN + 1),
  localparam int ADDR_W  = $clog2(MAX_LEN)
) (
  input  logic                   clock_25,
  input  logic                   reset,
  input  logic [9:0]             X,
  input  logic [9:0]             Y,
  input  logic [6:0]             snake_head_x,
  input  logic [6:0]             snake_head_y,
  input  logic [LEN_W-1:0]       snake_length,
  output logic [ADDR_W-1:0]      body_addr,
  input  logic [6:0]             snake_body_x,
  input  logic [6:0]             snake_body_y,
  input  logic [7*N_FRUIT-1:0]   fruit_x,
  input  logic [7*N_FRUIT-1:0]   fruit_y,
  input  logic [N_FRUIT-1:0]     fruit_valid,
  output logic [6:0]             x_block,
  output logic [6:0]             y_block,
  output logic [2:0]             x_local,
  output logic [2:0]             y_local,
  output logic                   game_area,
  output logic [1:0]             selected_figure,
  output logic [1:0]             color_data,
  output logic                   semaforo,
  output logic                   scan_overrun,
  output logic [1:0]             fsm_state
);

  localparam logic [10:0] AREA_X = 11'(8 * GRID_W);
  localparam logic [10:0] AREA_Y = 11'(8 * GRID_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [GRID_W-1:0] shadow_map;
  logic [GRID_W-1:0] display_map;
  logic [GRID_W-1:0] hit_mask;
  logic [6:0]        target_row;
  logic [6:0]        display_row;
  logic [6:0]        next_row;
  logic [LEN_W-1:0]  scan_len;
  logic              rd_valid;
  logic              trigger;
  logic              abort;
  logic              last_addr;

  logic [6:0] xb;
  logic [6:0] yb;
  logic       in_area;
  logic       head_hit;
  logic       body_hit;
  logic       fruit_hit;
  logic       grid_line;
  logic [1:0] fig_next;
  logic [1:0] col_next;

  assign semaforo  = (state != IDLE);
  assign fsm_state = state;

  // Scan control: trigger, abort, target row and last-address detection.
  always_comb begin
    trigger   = (X == 10'(H_ACTIVE)) && (Y[2:0] == 3'd7);
    abort     = (X == 10'd0);
    next_row  = (Y[9:3] >= 7'(GRID_H - 1)) ? 7'd0 : (Y[9:3] + 7'd1);
    // The MAX_LEN-1 term stops the scan even if snake_length is out of range.
    last_addr = (({{(32-ADDR_W){1'b0}}, body_addr} + 32'd1) >=
                 {{(32-LEN_W){1'b0}}, scan_len}) ||
                (body_addr == ADDR_W'(MAX_LEN - 1));
  end

  // Bitmap bits set by the segment currently returned from body memory.
  always_comb begin
    hit_mask = '0;
    for (int i = 0; i < GRID_W; i++) begin
      hit_mask[i] = (snake_body_y == target_row) && (snake_body_x == 7'(i));
    end
  end

  // FSM state register.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic. X == 0 means the visible line has started, so the scan is abandoned.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trigger && (snake_length != '0)) state_next = SCAN;
      SCAN:    if (abort) state_next = IDLE;
               else if (last_addr) state_next = DRAIN;
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Scan datapath: address counter, shadow build-up, and the display copy in DRAIN.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      body_addr    <= '0;
      shadow_map   <= '0;
      display_map  <= '0;
      target_row   <= '0;
      display_row  <= '0;
      scan_len     <= '0;
      rd_valid     <= 1'b0;
      scan_overrun <= 1'b0;
    end else begin
      rd_valid <= (state == SCAN) && !abort;
      case (state)
        IDLE: begin
          if (trigger) begin
            if (snake_length == '0) begin
              display_map <= '0;
            end else begin
              shadow_map <= '0;
              body_addr  <= '0;
              target_row <= next_row;
              scan_len   <= snake_length;
            end
          end
        end
        SCAN: begin
          if (abort) begin
            scan_overrun <= 1'b1;
          end else begin
            if (rd_valid) shadow_map <= shadow_map | hit_mask;
            if (!last_addr) body_addr <= body_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (abort) begin
            scan_overrun <= 1'b1;
          end else begin
            // The last segment arrives in this cycle, so merge it on the way into the display map.
            display_map <= shadow_map | hit_mask;
            display_row <= target_row;
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel classification: head > body > fruit > background.
  always_comb begin
    xb      = X[9:3];
    yb      = Y[9:3];
    in_area = ({1'b0, X} < AREA_X) && ({1'b0, Y} < AREA_Y);

    head_hit = (xb == snake_head_x) && (yb == snake_head_y);

    body_hit = 1'b0;
    for (int i = 0; i < GRID_W; i++) begin
      if (display_map[i] && (xb == 7'(i))) body_hit = 1'b1;
    end
    body_hit = body_hit && (yb == display_row);

    fruit_hit = 1'b0;
    for (int i = 0; i < N_FRUIT; i++) begin
      if (fruit_valid[i] && (fruit_x[7*i +: 7] == xb) && (fruit_y[7*i +: 7] == yb))
        fruit_hit = 1'b1;
    end

`ifdef SNAKE_RENDER_GRID_EN
    grid_line = (X[2:0] == 3'd0) || (Y[2:0] == 3'd0);
`else
    grid_line = 1'b0;
`endif

    fig_next = 2'b00;
    col_next = 2'b00;
    if (in_area) begin
      if (head_hit) begin
        fig_next = 2'b01;
        col_next = 2'b01;
      end else if (body_hit) begin
        fig_next = 2'b10;
        col_next = 2'b01;
      end else if (fruit_hit) begin
        fig_next = 2'b11;
        col_next = 2'b10;
      end else begin
        fig_next = 2'b00;
        col_next = grid_line ? 2'b11 : 2'b00;
      end
    end
  end

  // Pixel output register: one clock of latency from X/Y.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      x_block         <= '0;
      y_block         <= '0;
      x_local         <= '0;
      y_local         <= '0;
      game_area       <= 1'b0;
      selected_figure <= 2'b00;
      color_data      <= 2'b00;
    end else begin
      x_block         <= xb;
      y_block         <= yb;
      x_local         <= X[2:0];
      y_local         <= Y[2:0];
      game_area       <= in_area;
      selected_figure <= fig_next;
      color_data      <= col_next;
    end
  end

endmodule

// File: tb/tb_snake_render_engine.sv
// Testbench for snake_render_engine (MAX_LEN = 150, other parameters default).
// Pixel vectors live in one table and are applied group by group. Scan, overrun
// and reset sequences are written out by hand.
module tb_snake_render_engine;

  localparam int MAX_LEN = 150;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int ADDR_W  = $clog2(MAX_LEN);
`ifdef SNAKE_RENDER_GRID_EN
  localparam bit GRID_EN = 1'b1;
`else
  localparam bit GRID_EN = 1'b0;
`endif

  logic              clock_25;
  logic              reset;
  logic [9:0]        X, Y;
  logic [6:0]        snake_head_x, snake_head_y;
  logic [LEN_W-1:0]  snake_length;
  logic [ADDR_W-1:0] body_addr;
  logic [6:0]        snake_body_x, snake_body_y;
  logic [13:0]       fruit_x, fruit_y;
  logic [1:0]        fruit_valid;
  logic [6:0]        x_block, y_block;
  logic [2:0]        x_local, y_local;
  logic              game_area;
  logic [1:0]        selected_figure, color_data;
  logic              semaforo, scan_overrun;
  logic [1:0]        fsm_state;

  logic [6:0] mem_x [0:MAX_LEN-1];
  logic [6:0] mem_y [0:MAX_LEN-1];

  typedef struct {
    string      name;
    logic [9:0] x;
    logic [9:0] y;
    logic       ga;
    logic [1:0] fig;
    logic [1:0] col;
  } vec_t;

  vec_t tbl[$];
  int   g_bound[10];
  int   checks = 0;
  int   errors = 0;
  int   sem_cnt;

  snake_render_engine #(.MAX_LEN(MAX_LEN)) dut (
    .clock_25(clock_25), .reset(reset), .X(X), .Y(Y),
    .snake_head_x(snake_head_x), .snake_head_y(snake_head_y),
    .snake_length(snake_length), .body_addr(body_addr),
    .snake_body_x(snake_body_x), .snake_body_y(snake_body_y),
    .fruit_x(fruit_x), .fruit_y(fruit_y), .fruit_valid(fruit_valid),
    .x_block(x_block), .y_block(y_block), .x_local(x_local), .y_local(y_local),
    .game_area(game_area), .selected_figure(selected_figure), .color_data(color_data),
    .semaforo(semaforo), .scan_overrun(scan_overrun), .fsm_state(fsm_state)
  );

  // Clock/reset block
  initial begin
    clock_25 = 1'b0;
    forever #20 clock_25 = ~clock_25;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Body memory model: synchronous read, one cycle of latency.
  always @(posedge clock_25) begin
    snake_body_x <= mem_x[body_addr];
    snake_body_y <= mem_y[body_addr];
  end

  // Expected background colour: grid line only when the feature is built in.
  function automatic logic [1:0] gc(input int x, input int y);
    logic on_line;
    on_line = (x < 640) && (y < 480) && ((x % 8 == 0) || (y % 8 == 0));
    return (GRID_EN && on_line) ? 2'b11 : 2'b00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input int x, input int y, input logic ga,
                     input logic [1:0] fig, input logic [1:0] col);
    vec_t v;
    v.name = n; v.x = 10'(x); v.y = 10'(y); v.ga = ga; v.fig = fig; v.col = col;
    tbl.push_back(v);
  endtask

  // Driver: apply one table group, compare one cycle later (called at a negedge).
  task automatic run_group(input int g);
    for (int i = g_bound[g]; i < g_bound[g+1]; i++) begin
      X = tbl[i].x;
      Y = tbl[i].y;
      @(negedge clock_25);
      check({tbl[i].name, "_ga"},  32'(game_area),       32'(tbl[i].ga));
      check({tbl[i].name, "_fig"}, 32'(selected_figure), 32'(tbl[i].fig));
      check({tbl[i].name, "_col"}, 32'(color_data),      32'(tbl[i].col));
      check({tbl[i].name, "_blk"}, {12'd0, x_block, x_local, y_block, y_local},
            {12'd0, tbl[i].x, tbl[i].y});
    end
  endtask

  // Driver: trigger a scan at X=640, Y=23 and count the cycles with semaforo high.
  task automatic do_scan(output int cnt);
    cnt = 0;
    X = 10'd640;
    Y = 10'd23;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock_25);
      if (semaforo) cnt++;
      X = 10'(641 + i);
    end
  endtask

  task automatic load_body(input int x0, input int x1);
    mem_x[0] = 7'(x0);   mem_y[0] = 7'd3;
    mem_x[1] = 7'(x1);   mem_y[1] = 7'd3;
    mem_x[2] = 7'(x0);   mem_y[2] = 7'd4;
  endtask

  initial begin
    reset = 1'b0;
    X = '0; Y = '0;
    snake_head_x = 7'd5; snake_head_y = 7'd3;
    snake_length = '0;
    fruit_x = '0; fruit_y = '0; fruit_valid = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mem_x[i] = 7'd0;
      mem_y[i] = 7'd0;
    end

    // Group 0: head at (5,3), empty body, no fruit.
    g_bound[0] = tbl.size();
    add("h_x39", 39, 24, 1, 2'b00, gc(39, 24));
    add("h_x40", 40, 24, 1, 2'b01, 2'b01);
    add("h_x47", 47, 24, 1, 2'b01, 2'b01);
    add("h_x48", 48, 24, 1, 2'b00, gc(48, 24));
    add("h_y31", 44, 31, 1, 2'b01, 2'b01);
    add("h_y32", 44, 32, 1, 2'b00, gc(44, 32));
    add("out700", 700, 10, 0, 2'b00, 2'b00);
    add("edge639", 639, 479, 1, 2'b00, gc(639, 479));
    add("out640", 640, 100, 0, 2'b00, 2'b00);
    add("out480", 100, 480, 0, 2'b00, 2'b00);
    add("grid05", 0, 5, 1, 2'b00, gc(0, 5));
    // Group 1: body (6,3),(7,3) on row 3, head away.
    g_bound[1] = tbl.size();
    add("b47", 47, 24, 1, 2'b00, gc(47, 24));
    add("b48", 48, 24, 1, 2'b10, 2'b01);
    add("b55", 55, 27, 1, 2'b10, 2'b01);
    add("b63", 63, 31, 1, 2'b10, 2'b01);
    add("b64", 64, 24, 1, 2'b00, gc(64, 24));
    add("b_row4", 48, 32, 1, 2'b00, gc(48, 32));
    // Group 2: head on top of body segment (6,3).
    g_bound[2] = tbl.size();
    add("hb48", 48, 24, 1, 2'b01, 2'b01);
    add("hb56", 56, 24, 1, 2'b10, 2'b01);
    add("hb700", 700, 10, 0, 2'b00, 2'b00);
    // Group 3: fruit_valid=10, channel 1 at (10,3), channel 0 at (11,3).
    g_bound[3] = tbl.size();
    add("f80", 80, 24, 1, 2'b11, 2'b10);
    add("f87", 87, 31, 1, 2'b11, 2'b10);
    add("f88", 88, 24, 1, 2'b00, gc(88, 24));
    add("f95", 95, 25, 1, 2'b00, gc(95, 25));
    add("fb48", 48, 24, 1, 2'b10, 2'b01);
    // Group 4: both channels valid, channel 0 moved onto body (7,3).
    g_bound[4] = tbl.size();
    add("fp56", 56, 24, 1, 2'b10, 2'b01);
    add("fp80", 80, 24, 1, 2'b11, 2'b10);
    add("fp88", 88, 24, 1, 2'b00, gc(88, 24));
    // Group 5: after overrun, old bitmap kept.
    g_bound[5] = tbl.size();
    add("o48", 48, 24, 1, 2'b10, 2'b01);
    add("o240", 240, 24, 1, 2'b00, gc(240, 24));
    // Group 6: after zero-length trigger, bitmap cleared.
    g_bound[6] = tbl.size();
    add("z48", 48, 24, 1, 2'b00, gc(48, 24));
    add("z56", 56, 26, 1, 2'b00, gc(56, 26));
    // Group 7: after reset during a scan, no update.
    g_bound[7] = tbl.size();
    add("r240", 240, 24, 1, 2'b00, gc(240, 24));
    add("r48", 48, 24, 1, 2'b00, gc(48, 24));
    // Group 8: first scan after reset.
    g_bound[8] = tbl.size();
    add("n48", 48, 24, 1, 2'b10, 2'b01);
    add("n56", 56, 24, 1, 2'b10, 2'b01);
    add("n240", 240, 24, 1, 2'b00, gc(240, 24));
    g_bound[9] = tbl.size();

    // Reset state
    X = 10'd48; Y = 10'd24;
    repeat (2) @(negedge clock_25);
    check("rst_fig", 32'(selected_figure), 32'd0);
    check("rst_col", 32'(color_data), 32'd0);
    check("rst_ga", 32'(game_area), 32'd0);
    check("rst_sem", 32'(semaforo), 32'd0);
    check("rst_ovr", 32'(scan_overrun), 32'd0);
    check("rst_addr", 32'(body_addr), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    check("rst_blk", {12'd0, x_block, x_local, y_block, y_local}, 32'd0);
    reset = 1'b1;

    run_group(0);

    // Body scan of length 3
    load_body(6, 7);
    snake_length = 8'd3;
    snake_head_x = 7'd20; snake_head_y = 7'd20;
    do_scan(sem_cnt);
    check("scan_sem_cycles", 32'(sem_cnt), 32'd4);
    check("scan_ovr", 32'(scan_overrun), 32'd0);
    run_group(1);

    snake_head_x = 7'd6; snake_head_y = 7'd3;
    run_group(2);

    snake_head_x = 7'd20; snake_head_y = 7'd20;
    fruit_valid = 2'b10;
    fruit_x = {7'd10, 7'd11};
    fruit_y = {7'd3, 7'd3};
    run_group(3);
    fruit_valid = 2'b11;
    fruit_x = {7'd10, 7'd7};
    run_group(4);
    fruit_valid = 2'b00;

    // Overrun: a 150-segment scan is cut off by X wrapping to 0
    load_body(30, 31);
    snake_length = 8'd150;
    X = 10'd640; Y = 10'd23;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock_25);
      X = 10'(641 + i);
    end
    check("ovr_busy", 32'(semaforo), 32'd1);
    X = 10'd0;
    @(negedge clock_25);
    check("ovr_flag", 32'(scan_overrun), 32'd1);
    check("ovr_sem", 32'(semaforo), 32'd0);
    check("ovr_state", 32'(fsm_state), 32'd0);
    run_group(5);
    check("ovr_sticky", 32'(scan_overrun), 32'd1);

    // Zero length clears the display bitmap
    snake_length = 8'd0;
    X = 10'd640; Y = 10'd23;
    @(negedge clock_25);
    check("zero_sem", 32'(semaforo), 32'd0);
    run_group(6);

    // Reset in the middle of a scan
    snake_length = 8'd3;
    snake_head_x = 7'd6; snake_head_y = 7'd3;
    X = 10'd640; Y = 10'd23;
    @(negedge clock_25);
    check("mid_sem", 32'(semaforo), 32'd1);
    X = 10'd48; Y = 10'd24;
    @(negedge clock_25);
    check("mid_fig_pre", 32'(selected_figure), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_sem", 32'(semaforo), 32'd0);
    check("mid_rst_fig", 32'(selected_figure), 32'd0);
    check("mid_rst_col", 32'(color_data), 32'd0);
    check("mid_rst_ga", 32'(game_area), 32'd0);
    check("mid_rst_ovr", 32'(scan_overrun), 32'd0);
    check("mid_rst_addr", 32'(body_addr), 32'd0);
    check("mid_rst_state", 32'(fsm_state), 32'd0);
    @(negedge clock_25);
    reset = 1'b1;
    snake_head_x = 7'd20; snake_head_y = 7'd20;
    run_group(7);

    // Operation resumes at the next trigger
    load_body(6, 7);
    do_scan(sem_cnt);
    check("resume_sem_cycles", 32'(sem_cnt), 32'd4);
    run_group(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
